// File: rtl/clock_div_pkg.sv
// ---------------------------------------------------------------------------
// clock_div_pkg
//
// Shared definitions for the clock-enable divider and its ratio-change
// sequencer.
//   state_e        : sequencer states (RUN, DRAIN, HOLD)
//   quiesce_cnt_w  : width of a counter that has to reach QUIESCE_CYCLES
// ---------------------------------------------------------------------------
package clock_div_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Enough bits to count 0..quiesce_cycles inclusive.
  function automatic int quiesce_cnt_w(input int quiesce_cycles);
    return $clog2(quiesce_cycles + 1);
  endfunction

endpackage

// File: rtl/clock_div_counter.sv
// ---------------------------------------------------------------------------
// clock_div_counter
//
// Divisor counter with registered enable pulse and divide-by-2D level.
//   clock    : sole clock, rising edge
//   reset    : synchronous, active-high
//   run      : count and emit enables using div
//   clear    : force counter, en and div_clk to zero (has priority over run)
//   div      : active divisor; 0 means no enables and div_clk holds
//   en       : registered one-cycle enable pulse, every div cycles
//   div_clk  : registered level, toggles together with every en pulse
//   fall     : combinational, high in the cycle whose closing edge would
//              toggle div_clk from 1 to 0
// ---------------------------------------------------------------------------
module clock_div_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             clear,
  input  logic [CNT_W-1:0] div,
  output logic             en,
  output logic             div_clk,
  output logic             fall
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             div_clk_q, div_clk_d;
  logic [CNT_W:0]   cnt_inc;
  logic             hit;

  // The terminal-count compare is done one bit wider than the counter so
  // that a divisor of 2^CNT_W-1 never sees the increment wrap to zero.
  always_comb begin
    cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
    hit     = (div != '0) && (cnt_inc == {1'b0, div});
    fall    = hit && div_clk_q;
  end

  // Next-state for the counter, enable pulse and divided level.
  always_comb begin
    cnt_d     = cnt_q;
    en_d      = 1'b0;
    div_clk_d = div_clk_q;
    if (clear) begin
      cnt_d     = '0;
      div_clk_d = 1'b0;
    end else if (run) begin
      if (div == '0) begin
        cnt_d = '0;
      end else if (hit) begin
        cnt_d     = '0;
        en_d      = 1'b1;
        div_clk_d = ~div_clk_q;
      end else begin
        cnt_d = cnt_inc[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      en_q      <= 1'b0;
      div_clk_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      en_q      <= en_d;
      div_clk_q <= div_clk_d;
    end
  end

  assign en      = en_q;
  assign div_clk = div_clk_q;

endmodule

// File: rtl/clock_div_sequencer.sv
// ---------------------------------------------------------------------------
// clock_div_sequencer
//
// Programmable clock-enable divider with a glitch-free ratio-change
// sequencer. A new divisor is accepted on a valid/ready port, the output is
// drained to a low div_clk phase, enables are held off for QUIESCE_CYCLES,
// then the new ratio takes effect with the counter starting from zero.
//   clock      : sole clock, rising edge
//   reset      : synchronous, active-high
//   req_valid  : new divisor request
//   req_ready  : high in RUN; request accepted when req_valid && req_ready
//   req_div    : requested divisor, 0 = stop
//   en         : registered one-cycle enable pulse
//   div_clk    : registered level, toggles on every en pulse
//   cur_div    : active divisor
//   busy       : ratio change in progress
// ---------------------------------------------------------------------------
module clock_div_sequencer
  import clock_div_pkg::*;
#(
  parameter int CNT_W          = 8,
  parameter int QUIESCE_CYCLES = 4,
  parameter int RESET_DIV      = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CNT_W-1:0] req_div,
  output logic             en,
  output logic             div_clk,
  output logic [CNT_W-1:0] cur_div,
  output logic             busy
);

  localparam int               QW      = quiesce_cnt_w(QUIESCE_CYCLES);
  localparam logic [QW-1:0]    Q_LAST  = QW'(QUIESCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(RESET_DIV);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic [QW-1:0]    qcnt_q, qcnt_d;
  logic             cnt_run, cnt_clear, cnt_fall;

  // Sequencer next-state. DRAIN leaves on the edge where div_clk would fall,
  // so the divided clock always ends its old ratio on a complete low phase;
  // a stopped divider (cur_div 0) has nothing to drain.
  always_comb begin
    state_d   = state_q;
    cur_div_d = cur_div_q;
    pending_d = pending_q;
    qcnt_d    = '0;
    case (state_q)
      RUN: begin
        if (req_valid) begin
          pending_d = req_div;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        if ((cur_div_q == '0) || cnt_fall) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (qcnt_q == Q_LAST) begin
          state_d   = RUN;
          cur_div_d = pending_q;
        end else begin
          qcnt_d = qcnt_q + QW'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  // The counter is cleared on the edge that enters HOLD as well as through
  // HOLD itself. Clearing on entry suppresses the enable that would
  // accompany the final falling edge, so no en pulse lands in HOLD, and
  // clearing on the last HOLD edge makes the first RUN cycle start at zero.
  always_comb begin
    cnt_clear = (state_q == HOLD) || (state_d == HOLD);
    cnt_run   = !cnt_clear;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= RUN;
      cur_div_q <= RST_DIV;
      pending_q <= '0;
      qcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      cur_div_q <= cur_div_d;
      pending_q <= pending_d;
      qcnt_q    <= qcnt_d;
    end
  end

  clock_div_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clock   (clock),
    .reset   (reset),
    .run     (cnt_run),
    .clear   (cnt_clear),
    .div     (cur_div_q),
    .en      (en),
    .div_clk (div_clk),
    .fall    (cnt_fall)
  );

  assign req_ready = (state_q == RUN);
  assign busy      = (state_q != RUN);
  assign cur_div   = cur_div_q;

endmodule

// File: tb/tb_clock_div_sequencer.sv
// ---------------------------------------------------------------------------
// tb_clock_div_sequencer
//
// Directed bench for clock_div_sequencer (CNT_W=8, QUIESCE_CYCLES=4,
// RESET_DIV=1). Cycle n is the clock period following the n-th rising edge
// after reset release; outputs are sampled 1 time unit after each edge and
// compared against hand-derived per-cycle patterns.
// ---------------------------------------------------------------------------
module tb_clock_div_sequencer;

  logic       clock;
  logic       reset;
  logic       reqValid;
  logic       reqReady;
  logic [7:0] reqDiv;
  logic       en;
  logic       divClk;
  logic [7:0] curDiv;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  clock_div_sequencer #(
    .CNT_W          (8),
    .QUIESCE_CYCLES (4),
    .RESET_DIV      (1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (reqValid),
    .req_ready (reqReady),
    .req_div   (reqDiv),
    .en        (en),
    .div_clk   (divClk),
    .cur_div   (curDiv),
    .busy      (busy)
  );

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] time limit reached");
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // Drive the request port; takes effect at the next rising edge.
  task automatic applyStimulus(input logic valid, input logic [7:0] div);
    reqValid = valid;
    reqDiv   = div;
  endtask

  // Compare every output against the expected values for this cycle.
  task automatic checkOutput(input string tag, input logic expEn,
                             input logic expDivClk, input logic expBusy,
                             input logic [7:0] expDiv);
    checks++;
    assert (en === expEn) else begin
      errors++;
      $error("[TB] FAIL %s en cycle %0d: observed %b expected %b", tag, cyc, en, expEn);
    end
    checks++;
    assert (divClk === expDivClk) else begin
      errors++;
      $error("[TB] FAIL %s div_clk cycle %0d: observed %b expected %b", tag, cyc, divClk, expDivClk);
    end
    checks++;
    assert (busy === expBusy) else begin
      errors++;
      $error("[TB] FAIL %s busy cycle %0d: observed %b expected %b", tag, cyc, busy, expBusy);
    end
    checks++;
    assert (reqReady === !expBusy) else begin
      errors++;
      $error("[TB] FAIL %s req_ready cycle %0d: observed %b expected %b", tag, cyc, reqReady, !expBusy);
    end
    checks++;
    assert (curDiv === expDiv) else begin
      errors++;
      $error("[TB] FAIL %s cur_div cycle %0d: observed %0d expected %0d", tag, cyc, curDiv, expDiv);
    end
  endtask

  // Step n cycles; bit n-1 of each pattern is the first cycle checked.
  task automatic checkSeq(input string tag, input int n,
                          input logic [63:0] enBits, input logic [63:0] clkBits,
                          input logic expBusy, input logic [7:0] expDiv);
    for (int i = 0; i < n; i++) begin
      tick();
      checkOutput(tag, enBits[n-1-i], clkBits[n-1-i], expBusy, expDiv);
    end
  endtask

  initial begin
    reset    = 1'b1;
    reqValid = 1'b0;
    reqDiv   = 8'd0;
    tick();
    tick();
    reset = 1'b0;
    cyc   = 0;
    $display("[TB] reset released");

    // Cycle 0: reset values.
    checkOutput("reset", 1'b0, 1'b0, 1'b0, 8'd1);

    // Divide-by-1: en every cycle, div_clk toggles every cycle.
    checkSeq("div1", 6, 6'b111111, 6'b101010, 1'b0, 8'd1);

    // Request D=3 at cycle 6; DRAIN cycle 7, HOLD 8..11, RUN from 12.
    applyStimulus(1'b1, 8'd3);
    checkSeq("drain3", 1, 1'b1, 1'b1, 1'b1, 8'd1);
    applyStimulus(1'b0, 8'd0);
    checkSeq("hold3", 4, '0, '0, 1'b1, 8'd1);
    checkSeq("run3", 12, 12'b000100100100, 12'b000111000111, 1'b0, 8'd3);

    // Request D=0 with div_clk high; drains through a full low/high phase.
    applyStimulus(1'b1, 8'd0);
    checkSeq("drain0a", 1, 1'b1, 1'b0, 1'b1, 8'd3);
    applyStimulus(1'b0, 8'd0);
    checkSeq("drain0b", 5, 5'b00100, 5'b00111, 1'b1, 8'd3);
    checkSeq("hold0", 4, '0, '0, 1'b1, 8'd3);
    checkSeq("run0", 6, '0, '0, 1'b0, 8'd0);

    // Request D=5 from stop: HOLD the cycle after accept. A different value
    // held on the port while busy is ignored.
    applyStimulus(1'b1, 8'd5);
    checkSeq("drain5", 1, '0, '0, 1'b1, 8'd0);
    applyStimulus(1'b1, 8'd9);
    checkSeq("hold5", 4, '0, '0, 1'b1, 8'd0);
    applyStimulus(1'b0, 8'd0);
    checkSeq("run5", 20, 20'b00000100001000010000, 20'b00000111110000011111, 1'b0, 8'd5);

    // Request D=7, then reset in HOLD; 7 must never reach cur_div.
    applyStimulus(1'b1, 8'd7);
    checkSeq("drain7a", 1, 1'b1, 1'b0, 1'b1, 8'd5);
    applyStimulus(1'b1, 8'd9);
    checkSeq("drain7b", 9, 9'b000010000, 9'b000011111, 1'b1, 8'd5);
    checkSeq("hold7", 2, '0, '0, 1'b1, 8'd5);
    reset = 1'b1;
    checkSeq("abort", 1, '0, '0, 1'b0, 8'd1);
    reset = 1'b0;

    // The value on the port at the first RUN cycle (9) is accepted.
    checkSeq("drain9", 1, 1'b1, 1'b1, 1'b1, 8'd1);
    applyStimulus(1'b0, 8'd0);
    checkSeq("hold9", 4, '0, '0, 1'b1, 8'd1);
    checkSeq("run9", 10, 10'b0000000001, 10'b0000000001, 1'b0, 8'd9);

    // Maximum divisor 255.
    applyStimulus(1'b1, 8'd255);
    checkSeq("drain255a", 1, '0, 1'b1, 1'b1, 8'd9);
    applyStimulus(1'b0, 8'd0);
    checkSeq("drain255b", 7, '0, 7'h7F, 1'b1, 8'd9);
    checkSeq("hold255", 4, '0, '0, 1'b1, 8'd9);

    // D=255 runs with en exactly at relative cycle 255; a repeat request
    // for 255 then still drains through the next div_clk fall.
    for (int i = 0; i < 510; i++) begin
      tick();
      checkOutput("run255", (i == 255), (i >= 255), (i >= 256), 8'd255);
      if (i == 255) applyStimulus(1'b1, 8'd255);
      if (i == 256) applyStimulus(1'b0, 8'd0);
    end
    checkSeq("hold255b", 4, '0, '0, 1'b1, 8'd255);
    checkSeq("run255b", 3, '0, '0, 1'b0, 8'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
